serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder that sits directly downstream of the `halfAdder` cell and is built from it. The block accepts two operands and a carry-in through a valid/ready handshake. It adds them LSB-first, one bit per clock, through a single full-adder cell with a registered carry. It then presents the WIDTH-bit sum and carry-out through a second valid/ready handshake. It trades latency for area: one adder cell per block instead of one per bit.

## Interface
- `WIDTH`, default 8: operand and sum width in bits, ≥ 1.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands on `a`, `b`, `cin` are valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in.
- `out_valid`  out  1  `sum`/`cout` hold a completed result.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  result bits, (a+b+cin) mod 2^WIDTH.
- `cout`  out  1  carry-out of bit WIDTH-1.

## Operation
- FSM states and transitions:
  - IDLE → ADD on `in_valid && in_ready`.
  - ADD → DONE after WIDTH bit-steps.
  - DONE → IDLE on `out_valid && out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are decoded from registered state.
- On accept:
  - `a` and `b` load into shift registers `sa` and `sb`.
  - `cin` loads into carry register `c`.
  - Bit counter `cnt` clears to 0.
  - The result shift register is cleared.
- Each ADD cycle:
  - The full-adder cell computes `s = sa[0]^sb[0]^c` and `co`.
  - `s` shifts into the MSB of the result register, which shifts right.
  - `sa` and `sb` shift right.
  - `c` ← `co`.
  - `cnt` ← `cnt+1`.
- Leave ADD when `cnt == WIDTH-1` is being processed; after WIDTH steps the result register holds the sum in natural bit order.
- `sum` is driven from the result register and `cout` from `c`. Both are meaningful only while `out_valid` is high.
- `a`, `b`, `cin` are sampled only at the accept edge. Changes during ADD or DONE are ignored.
- There is no overlap. A new operand is never accepted while in ADD or DONE, including in the cycle DONE completes.
- `cnt` width is `$clog2(WIDTH)`, with a minimum of 1. WIDTH = 1 must work: a single ADD cycle.
- Reset, asserted at any time including mid-ADD:
  - State → IDLE; `sa`, `sb`, result, `c`, `cnt` → 0.
  - The in-flight operation is discarded and no result is produced.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0.
- Accept at rising edge E0. ADD occupies the cycles after E0 through E0+WIDTH.
- `out_valid` rises after edge E0+WIDTH, i.e. the acceptance-to-result latency is WIDTH cycles.
- `in_ready` is low from the cycle after E0 until the cycle after the output handshake edge.
- Minimum throughput: one operation per WIDTH+2 cycles (accept, WIDTH ADD, one DONE cycle with `out_ready` high).
- While in DONE with `out_ready` low, `sum`, `cout` and `out_valid` hold stable indefinitely.
- `out_valid` never drops without a handshake, except on reset.
- No combinational path from inputs to outputs.

## Structure
- Shared package/header `serial_adder_pkg`:
  - FSM state encodings as localparams: IDLE=2'd0, ADD=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH constant.
- One sub-module: `full_adder_bit`. It is built from two `halfAdder` instances plus an OR of their carries, and is instantiated once.
- All sequential logic (FSM, shift registers, counter, carry flop) lives in `serial_adder`.

## Test plan
All scenarios use WIDTH=8.
- **Basic add:** `a`=0x5A, `b`=0x33, `cin`=0 → `sum`=0x8D, `cout`=0. `out_valid` rises exactly 8 cycles after the accept edge.
- **Overflow:**
  - `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1.
  - `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises → `sum`/`cout`/`out_valid` stable, `in_ready`=0 throughout. The handshake then returns the FSM to IDLE with `in_ready`=1 on the next cycle.
- **Input isolation:** change `a`/`b` to 0x00 and pulse `in_valid` during ADD → no second accept, result still matches the originally sampled operands.
- **Reset mid-operation:** assert `rst_n`=0 three cycles into ADD → asynchronously `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0. After release, a new add 0x10+0x20 yields `sum`=0x30.
- **Back-to-back:** present `in_valid` continuously with `out_ready`=1 for three operations → each accept is spaced 10 cycles apart and all three sums are correct.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/halfAdder.sv
// Single-bit half adder cell.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder composed of two half adders and an OR of their carries.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1, c1, c2;

  halfAdder u_ha0 (.a(a),  .b(b),  .sum(s1), .carry(c1));
  halfAdder u_ha1 (.a(s1), .b(ci), .sum(s),  .carry(c2));

  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell with a registered
// carry, valid/ready handshakes on both operand input and result output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, nstate;
  logic [WIDTH-1:0] sa, sb, res, res_nx;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s, co;
  logic             accept, last;

  full_adder_bit u_fa (.a(sa[0]), .b(sb[0]), .ci(c), .s(s), .co(co));

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid)  nstate = ADD;
      ADD:     if (last)      nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Result shifts right with the new bit entering at the MSB; written this way so WIDTH=1 stays legal.
  always_comb begin
    res_nx            = res >> 1;
    res_nx[WIDTH-1]   = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        c   <= cin;
        cnt <= '0;
        res <= '0;
      end else if (state == ADD) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        c   <= co;
        cnt <= cnt + CW'(1);
        res <= res_nx;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = res;
  assign cout      = c;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, scoreboard queue, corner sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nres = 0;
  int   npush = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", sum);
      end else begin
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.co);
        nres++;
      end
    end
  end

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout_in_ready actual=0 required=1");
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout_out_valid actual=0 required=1");
    end
  endtask

  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] es, input logic eco, output int acc);
    wait_ready();
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(posedge clk);
    q.push_back('{s: es, co: eco});
    npush++;
    #1 in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic eco);
    int acc;
    bit ok;
    start_op(va, vb, vc, es, eco, acc);
    wait_out(ok);
    if (ok) chk("latency", 64'(cyc - acc), 64'd8);
    @(posedge clk);
    #1;
  endtask

  vec_t vt[10];

  initial begin : main
    int acc;
    bit ok;
    logic [7:0] s0;
    int accs[3];
    logic [7:0] ba[3], bb[3], bs[3];
    logic       bc[3], bco[3];

    vt[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vt[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    for (int i = 6; i < 10; i++) begin
      logic [8:0] t;
      vt[i].a   = 8'($urandom_range(0, 255));
      vt[i].b   = 8'($urandom_range(0, 255));
      vt[i].cin = 1'($urandom_range(0, 1));
      t = 9'(vt[i].a) + 9'(vt[i].b) + 9'(vt[i].cin);
      vt[i].s  = t[7:0];
      vt[i].co = t[8];
    end

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co);

    // Input isolation: operands change and in_valid pulses during ADD
    start_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, acc);
    @(negedge clk);
    a = 8'h00; b = 8'h00; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("iso_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    wait_out(ok);
    if (ok) chk("iso_latency", 64'(cyc - acc), 64'd8);
    @(posedge clk); #1;
    @(negedge clk);
    chk("iso_no_second_accept", {in_ready, out_valid}, 2'b10);

    // Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_op(8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, acc);
    wait_out(ok);
    if (ok) chk("bp_latency", 64'(cyc - acc), 64'd8);
    s0 = sum;
    chk("bp_sum_first", s0, 8'h00);
    repeat (5) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, s0);
      chk("bp_cout", cout, 1);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_done", {in_ready, out_valid}, 2'b01);
    @(negedge clk);
    chk("bp_after_hs", {in_ready, out_valid}, 2'b10);

    // Reset three cycles into ADD
    @(posedge clk); #1;
    start_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    npush -= q.size();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // Back-to-back with in_valid held high
    ba = '{8'h01, 8'h7F, 8'hF0};
    bb = '{8'h02, 8'h01, 8'h0F};
    bc = '{1'b0, 1'b1, 1'b0};
    bs = '{8'h03, 8'h81, 8'hFF};
    bco = '{1'b0, 1'b0, 1'b0};
    a = ba[0]; b = bb[0]; cin = bc[0]; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      accs[k] = cyc;
      @(posedge clk);
      q.push_back('{s: bs[k], co: bco[k]});
      npush++;
      #1;
      if (k < 2) begin
        a = ba[k+1]; b = bb[k+1]; cin = bc[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_spacing01", 64'(accs[1] - accs[0]), 64'd10);
    chk("b2b_spacing12", 64'(accs[2] - accs[1]), 64'd10);
    repeat (12) @(negedge clk);

    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("result_count", 64'(nres), 64'(npush));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
